// File: rtl/result_streamer_if.sv
// Handshake bundle between the matrix multiplier, result_streamer and the byte consumer.
// master: multiplier/consumer side; slave: result_streamer side.
`timescale 1ns/1ps
interface result_streamer_if #(
  parameter int ELEM_W = 16,
  parameter int N_ELEM = 4,
  parameter int BYTE_W = 8
);
  logic [ELEM_W*N_ELEM-1:0] res_mat;
  logic                     res_ready;
  logic [3:0]               res_count;
  logic [BYTE_W-1:0]        out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic                     busy;
  logic                     done;

  modport master (
    output res_mat, res_ready, res_count, out_ready,
    input  out_data, out_valid, busy, done
  );

  modport slave (
    input  res_mat, res_ready, res_count, out_ready,
    output out_data, out_valid, busy, done
  );
endinterface

// File: rtl/result_streamer.sv
// Captures the multiplier result word on a rise of res_ready and streams it out one byte per beat.
// Optional CHECKSUM_EN appends one XOR-of-data beat after the last data byte.
`timescale 1ns/1ps
module result_streamer #(
  parameter int ELEM_W = 16,
  parameter int N_ELEM = 4,
  parameter int BYTE_W = 8
) (
  input  logic          CLK,
  input  logic          RST,
  result_streamer_if.slave bus
);
  localparam int WORD_W = ELEM_W * N_ELEM;
  localparam int BPE    = ELEM_W / BYTE_W;
  localparam int BW     = (BPE > 1) ? $clog2(BPE) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
`ifdef CHECKSUM_EN
    S_CSUM,
`endif
    S_FINISH
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_prev_ready;
  logic                r_armed;
  logic [WORD_W-1:0]   r_shadow;
  logic [3:0]          r_count;
  logic [3:0]          r_elem;
  logic [BW-1:0]       r_byte;
`ifdef CHECKSUM_EN
  logic [BYTE_W-1:0]   r_csum;
`endif
  logic                w_start;
  logic                w_accept;
  logic                w_last;
  logic [3:0]          w_clamp;
  logic [BYTE_W-1:0]   w_data;
  logic                w_valid;
  logic                w_busy;
  logic                w_done;

  assign w_clamp  = (bus.res_count > 4'(N_ELEM)) ? 4'(N_ELEM) : bus.res_count;
  // r_armed stays low until res_ready is seen low after reset, so a level
  // already high at reset release is not mistaken for a rising edge.
  assign w_start  = bus.res_ready && !r_prev_ready && r_armed;
  assign w_accept = w_valid && bus.out_ready;
  assign w_last   = (r_byte == BW'(BPE - 1)) && (r_elem == r_count - 4'd1);

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_valid = 1'b0;
    w_busy  = 1'b0;
    w_done  = 1'b0;
    w_data  = '0;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_next = S_LOAD;
      end
      S_LOAD: begin
        w_busy = 1'b1;
        w_next = (w_clamp == 4'd0) ? S_FINISH : S_SEND;
      end
      S_SEND: begin
        w_valid = 1'b1;
        w_busy  = 1'b1;
        w_data  = r_shadow[WORD_W-1 -: BYTE_W];
        if (bus.out_ready && w_last) begin
`ifdef CHECKSUM_EN
          w_next = S_CSUM;
`else
          w_next = S_FINISH;
`endif
        end
      end
`ifdef CHECKSUM_EN
      S_CSUM: begin
        w_valid = 1'b1;
        w_busy  = 1'b1;
        w_data  = r_csum;
        if (bus.out_ready) w_next = S_FINISH;
      end
`endif
      S_FINISH: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_prev_ready <= 1'b0;
      r_armed      <= 1'b0;
      r_shadow     <= '0;
      r_count      <= '0;
      r_elem       <= '0;
      r_byte       <= '0;
`ifdef CHECKSUM_EN
      r_csum       <= '0;
`endif
    end else begin
      r_prev_ready <= bus.res_ready;
      if (!bus.res_ready) r_armed <= 1'b1;
      if (r_state == S_LOAD) begin
        r_shadow <= bus.res_mat;
        r_count  <= w_clamp;
        r_elem   <= '0;
        r_byte   <= '0;
`ifdef CHECKSUM_EN
        r_csum   <= '0;
`endif
      end else if (r_state == S_SEND && w_accept) begin
        // Shadow shifts left so the next byte is always at the top.
        r_shadow <= {r_shadow[WORD_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
`ifdef CHECKSUM_EN
        r_csum   <= r_csum ^ w_data;
`endif
        if (r_byte == BW'(BPE - 1)) begin
          r_byte <= '0;
          r_elem <= r_elem + 4'd1;
        end else begin
          r_byte <= r_byte + 1'b1;
        end
      end
    end
  end

  assign bus.out_data  = w_data;
  assign bus.out_valid = w_valid;
  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
endmodule

// File: tb/tb_result_streamer.sv
// Directed bench for result_streamer: checks at negedge, inputs changed at negedge.
`timescale 1ns/1ps
module tb_result_streamer;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  result_streamer_if #(.ELEM_W(16), .N_ELEM(4), .BYTE_W(8)) bus();

  result_streamer #(.ELEM_W(16), .N_ELEM(4), .BYTE_W(8)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Called at the negedge showing the first data beat, with out_ready held high.
  task automatic stream_full(input string tag, input logic [63:0] w, input int n);
    logic [7:0] b;
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      b = 8'((w >> (56 - 8 * i)) & 64'hff);
      x = x ^ b;
      chk({tag, " valid"}, bus.out_valid, 1);
      chk({tag, " data"}, bus.out_data, b);
      step();
    end
`ifdef CHECKSUM_EN
    chk({tag, " csum valid"}, bus.out_valid, 1);
    chk({tag, " csum data"}, bus.out_data, x);
    step();
`endif
    chk({tag, " done"}, bus.done, 1);
    chk({tag, " busy at finish"}, bus.busy, 0);
    chk({tag, " valid at finish"}, bus.out_valid, 0);
    step();
    chk({tag, " done pulse width"}, bus.done, 0);
  endtask

  initial begin
    logic [63:0] w_a;
    logic [63:0] w_b;
    logic [7:0]  b;
    w_a = 64'h0011_2233_4455_6677;
    w_b = 64'hFFEE_DDCC_BBAA_9988;

    rst           = 1'b1;
    bus.res_mat   = '0;
    bus.res_ready = 1'b0;
    bus.res_count = 4'd0;
    bus.out_ready = 1'b0;
    step(); step();
    chk("reset valid", bus.out_valid, 0);
    chk("reset busy", bus.busy, 0);
    chk("reset done", bus.done, 0);
    chk("reset data", bus.out_data, 0);
    rst = 1'b0;
    step();
    chk("idle busy", bus.busy, 0);

    // 1: full word, consumer always ready
    bus.res_mat = w_a; bus.res_count = 4'd4; bus.out_ready = 1'b1; bus.res_ready = 1'b1;
    step();
    chk("t1 load busy", bus.busy, 1);
    chk("t1 load valid", bus.out_valid, 0);
    step();
    stream_full("t1", w_a, 8);
    bus.res_ready = 1'b0;
    step();

    // 2: two elements, consumer stalls every other cycle
    bus.res_count = 4'd2; bus.res_ready = 1'b1;
    step();
    chk("t2 load busy", bus.busy, 1);
    bus.out_ready = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin
      b = 8'((w_a >> (56 - 8 * k)) & 64'hff);
      chk("t2 valid", bus.out_valid, 1);
      chk("t2 data", bus.out_data, b);
      step();
      chk("t2 stall valid", bus.out_valid, 1);
      chk("t2 stall data", bus.out_data, b);
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
    end
`ifdef CHECKSUM_EN
    chk("t2 csum data", bus.out_data, 8'h00);
    step();
    chk("t2 csum stall valid", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    step();
`endif
    chk("t2 done", bus.done, 1);
    chk("t2 valid at finish", bus.out_valid, 0);
    step();
    chk("t2 done once a", bus.done, 0);
    step();
    chk("t2 done once b", bus.done, 0);
    chk("t2 idle busy", bus.busy, 0);
    bus.res_ready = 1'b0;
    step();

    // 3: empty result, then over-range count clamps to 4 elements
    bus.res_count = 4'd0; bus.res_ready = 1'b1;
    step();
    chk("t3 empty load busy", bus.busy, 1);
    chk("t3 empty load valid", bus.out_valid, 0);
    step();
    chk("t3 empty done", bus.done, 1);
    chk("t3 empty busy", bus.busy, 0);
    chk("t3 empty valid", bus.out_valid, 0);
    step();
    chk("t3 empty after done", bus.done, 0);
    chk("t3 empty after valid", bus.out_valid, 0);
    bus.res_ready = 1'b0;
    step();
    bus.res_count = 4'd9; bus.out_ready = 1'b1; bus.res_ready = 1'b1;
    step();
    chk("t3 clamp load busy", bus.busy, 1);
    step();
    stream_full("t3 clamp", w_a, 8);
    bus.res_ready = 1'b0;
    step();

    // 4: res_ready held high, res_mat changed mid-stream
    bus.res_count = 4'd4; bus.res_ready = 1'b1;
    step(); step();
    bus.res_mat = w_b;
    stream_full("t4", w_a, 8);
    for (int k = 0; k < 3; k++) begin
      chk("t4 no restart busy", bus.busy, 0);
      chk("t4 no restart valid", bus.out_valid, 0);
      step();
    end
    bus.res_ready = 1'b0;
    step();
    bus.res_ready = 1'b1;
    step();
    chk("t4 second load busy", bus.busy, 1);
    step();
    chk("t4 second data 0", bus.out_data, 8'hFF);
    step();
    chk("t4 second data 1", bus.out_data, 8'hEE);
    step();
    chk("t4 second data 2", bus.out_data, 8'hDD);
    step();

    // 5: reset after third accepted beat, res_ready stays high through reset
    chk("t5 data before reset", bus.out_data, 8'hCC);
    rst = 1'b1;
    step();
    chk("t5 reset valid", bus.out_valid, 0);
    chk("t5 reset busy", bus.busy, 0);
    chk("t5 reset done", bus.done, 0);
    chk("t5 reset data", bus.out_data, 0);
    rst = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin
      chk("t5 no start busy", bus.busy, 0);
      chk("t5 no start done", bus.done, 0);
      step();
    end
    bus.res_ready = 1'b0;
    step();
    bus.res_ready = 1'b1;
    step();
    chk("t5 fresh rise busy", bus.busy, 1);
    step();
    stream_full("t5 restart", w_b, 8);
    bus.res_ready = 1'b0;
    step();

`ifdef CHECKSUM_EN
    // 6: checksum beat is XOR of 01..08
    bus.res_mat = 64'h0102_0304_0506_0708; bus.res_count = 4'd4; bus.res_ready = 1'b1;
    step(); step();
    for (int k = 0; k < 8; k++) begin
      chk("t6 data", bus.out_data, 64'(k + 1));
      step();
    end
    chk("t6 csum valid", bus.out_valid, 1);
    chk("t6 csum", bus.out_data, 8'h08);
    step();
    chk("t6 done", bus.done, 1);
    bus.res_ready = 1'b0;
    step();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
